// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and bound helpers for sprite motion and the renderer
package sprite_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CALC_X,
    CALC_Y,
    COMMIT
  } state_t;

  // Legal centre range keeps the whole sprite inside the visible area.
  function automatic coord_t x_min(input int radius);
    return coord_t'(radius);
  endfunction

  function automatic coord_t x_max(input int width, input int radius);
    return coord_t'(width - 1 - radius);
  endfunction

  function automatic coord_t y_min(input int radius);
    return coord_t'(radius);
  endfunction

  function automatic coord_t y_max(input int height, input int radius);
    return coord_t'(height - 1 - radius);
  endfunction

  function automatic coord_t clamp_coord(input coord_t v, input coord_t lo, input coord_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// rtl/sprite_motion_ctrl_if.sv - scan, control and position signals between driver and motion controller
interface sprite_motion_ctrl_if;
  import sprite_pkg::*;

  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        enable;
  logic [2:0]  step;
  logic        load_en;
  coord_t      load_x;
  coord_t      load_y;
  coord_t      x_pos;
  coord_t      y_pos;
  logic        dir_x;
  logic        dir_y;
  logic        frame_tick;
  logic        bounce_x;
  logic        bounce_y;

  modport master (
    output h_count, v_count, enable, step, load_en, load_x, load_y,
    input  x_pos, y_pos, dir_x, dir_y, frame_tick, bounce_x, bounce_y
  );

  modport slave (
    input  h_count, v_count, enable, step, load_en, load_x, load_y,
    output x_pos, y_pos, dir_x, dir_y, frame_tick, bounce_x, bounce_y
  );

endinterface

// File: rtl/sprite_motion_ctrl_axis_reflect.sv
// rtl/sprite_motion_ctrl_axis_reflect.sv - one-axis step with clamp and reflection at the range edges
module axis_reflect
  import sprite_pkg::*;
(
  input  coord_t     pos,
  input  logic       dir,
  input  logic [2:0] step,
  input  coord_t     lo,
  input  coord_t     hi,
  output coord_t     npos,
  output logic       ndir,
  output logic       bounce
);

  logic signed [11:0] sum;

  always_comb begin
    sum    = '0;
    npos   = pos;
    ndir   = dir;
    bounce = 1'b0;
    if (dir) begin
      sum = $signed({1'b0, pos}) + $signed({9'd0, step});
    end else begin
      sum = $signed({1'b0, pos}) - $signed({9'd0, step});
    end
    npos = sum[10:0];
    // Landing exactly on a bound is legal; only overshoot reflects.
    if (dir && (sum > $signed({1'b0, hi}))) begin
      npos   = hi;
      ndir   = 1'b0;
      bounce = 1'b1;
    end else if (!dir && (sum < $signed({1'b0, lo}))) begin
      npos   = lo;
      ndir   = 1'b1;
      bounce = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - frame-paced bouncing sprite position sequencer, updates only in vblank
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int WIDTH     = 800,
  parameter int HEIGHT    = 600,
  parameter int RADIUS    = 17,
  parameter int FRAME_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sprite_motion_ctrl_if.slave bus
);

  localparam coord_t     XMIN     = x_min(RADIUS);
  localparam coord_t     XMAX     = x_max(WIDTH, RADIUS);
  localparam coord_t     YMIN     = y_min(RADIUS);
  localparam coord_t     YMAX     = y_max(HEIGHT, RADIUS);
  localparam coord_t     X_HOME   = coord_t'(WIDTH / 2);
  localparam coord_t     Y_HOME   = coord_t'(HEIGHT / 2);
  localparam logic [10:0] V_END   = 11'(HEIGHT);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  state_t     state;
  coord_t     x_pos;
  coord_t     y_pos;
  coord_t     nx;
  coord_t     ny;
  logic       dir_x;
  logic       dir_y;
  logic       frame_tick;
  logic       bounce_x;
  logic       bounce_y;
  logic [7:0] div_cnt;

  logic   frame_end;
  coord_t nx_c;
  coord_t ny_c;
  logic   ndx_c;
  logic   ndy_c;
  logic   bx_c;
  logic   by_c;

  assign frame_end = (bus.v_count == V_END) && (bus.h_count == 11'd0);

  axis_reflect u_x (
    .pos    (x_pos),
    .dir    (dir_x),
    .step   (bus.step),
    .lo     (XMIN),
    .hi     (XMAX),
    .npos   (nx_c),
    .ndir   (ndx_c),
    .bounce (bx_c)
  );

  axis_reflect u_y (
    .pos    (y_pos),
    .dir    (dir_y),
    .step   (bus.step),
    .lo     (YMIN),
    .hi     (YMAX),
    .npos   (ny_c),
    .ndir   (ndy_c),
    .bounce (by_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_pos      <= X_HOME;
      y_pos      <= Y_HOME;
      nx         <= X_HOME;
      ny         <= Y_HOME;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      frame_tick <= 1'b0;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      div_cnt    <= 8'd0;
    end else begin
      frame_tick <= frame_end;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_en) begin
            x_pos <= clamp_coord(bus.load_x, XMIN, XMAX);
            y_pos <= clamp_coord(bus.load_y, YMIN, YMAX);
          end
          if (bus.enable) state <= WAIT;
        end
        WAIT: begin
          if (!bus.enable) begin
            state <= IDLE;
          end else if (frame_tick) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= 8'd0;
              state   <= CALC_X;
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end
        CALC_X: begin
          nx       <= nx_c;
          dir_x    <= ndx_c;
          bounce_x <= bx_c;
          state    <= CALC_Y;
        end
        CALC_Y: begin
          ny       <= ny_c;
          dir_y    <= ndy_c;
          bounce_y <= by_c;
          state    <= COMMIT;
        end
        COMMIT: begin
          // Both axes land together so the renderer never sees a half-moved sprite.
          x_pos <= nx;
          y_pos <= ny;
          state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_pos      = x_pos;
  assign bus.y_pos      = y_pos;
  assign bus.dir_x      = dir_x;
  assign bus.dir_y      = dir_y;
  assign bus.frame_tick = frame_tick;
  assign bus.bounce_x   = bounce_x;
  assign bus.bounce_y   = bounce_y;

endmodule
